// File: rtl/qkv_pkg.sv
// rtl/qkv_pkg.sv - shared types and constants for the Q/K/V requantizing serializer
package qkv_pkg;

   localparam int SHIFT_W = 5;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   function automatic int acc_width(input int dw, input int n);
      return 2 * dw + $clog2(n);
   endfunction

endpackage

// File: rtl/qkv_requant_serializer_requant_sat.sv
// rtl/qkv_requant_serializer_requant_sat.sv - rounding arithmetic right shift then signed saturation
module requant_sat
   import qkv_pkg::*;
#(
   parameter int ACC_W = 18,
   parameter int DW    = 4
)(
   input  logic signed [ACC_W-1:0] x,
   input  logic [SHIFT_W-1:0]      s,
   output logic signed [DW-1:0]    r,
   output logic                    sat
);

   // One guard bit so the rounding add can never wrap.
   localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'(2**(DW-1) - 1);
   localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

   logic [SHIFT_W-1:0]   s_eff;
   logic signed [ACC_W:0] ext;
   logic signed [ACC_W:0] rnd;
   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] shifted;

   always_comb begin
      s_eff   = (s > SHIFT_W'(ACC_W - 1)) ? SHIFT_W'(ACC_W - 1) : s;
      ext     = {x[ACC_W-1], x};
      rnd     = '0;
      if (s_eff != '0) begin
         rnd[s_eff - 1'b1] = 1'b1;
      end
      sum     = ext + rnd;
      shifted = sum >>> s_eff;
      sat     = 1'b0;
      r       = shifted[DW-1:0];
      if (shifted > MAX_V) begin
         r   = MAX_V[DW-1:0];
         sat = 1'b1;
      end else if (shifted < MIN_V) begin
         r   = MIN_V[DW-1:0];
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/qkv_requant_serializer.sv
// rtl/qkv_requant_serializer.sv - captures a Q/K/V frame and streams requantized heads; QKV_SAT_CNT_EN adds sat_count
module qkv_requant_serializer
   import qkv_pkg::*;
#(
   parameter int  PE_NUM = 12,
   parameter int  DW     = 4,
   parameter int  N      = 768,
   localparam int ACC_W  = acc_width(DW, N),
   localparam int HW     = $clog2(PE_NUM)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [ACC_W-1:0] in_q [0:PE_NUM-1],
   input  logic signed [ACC_W-1:0] in_k [0:PE_NUM-1],
   input  logic signed [ACC_W-1:0] in_v [0:PE_NUM-1],
   input  logic [SHIFT_W-1:0]      shift_amt,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [HW-1:0]           out_head,
   output logic signed [DW-1:0]    out_q,
   output logic signed [DW-1:0]    out_k,
   output logic signed [DW-1:0]    out_v,
   output logic                    out_last,
   output logic                    busy,
   output logic                    overflow
`ifdef QKV_SAT_CNT_EN
   ,
   output logic [15:0]             sat_count
`endif
);

   localparam logic [HW-1:0] LAST = HW'(PE_NUM - 1);

   state_t                  state;
   logic [HW-1:0]           head;
   logic signed [ACC_W-1:0] q_buf [0:PE_NUM-1];
   logic signed [ACC_W-1:0] k_buf [0:PE_NUM-1];
   logic signed [ACC_W-1:0] v_buf [0:PE_NUM-1];
   logic [SHIFT_W-1:0]      shift_reg;

   logic                    accept;
   logic                    last_acc;
   logic                    load;
   logic                    adv;
   logic [HW-1:0]           nxt_head;
   logic signed [ACC_W-1:0] sel_q;
   logic signed [ACC_W-1:0] sel_k;
   logic signed [ACC_W-1:0] sel_v;
   logic [SHIFT_W-1:0]      sel_s;
   logic signed [DW-1:0]    rq_q;
   logic signed [DW-1:0]    rq_k;
   logic signed [DW-1:0]    rq_v;
   logic                    sat_q;
   logic                    sat_k;
   logic                    sat_v;

   // The requantizers look one beat ahead so every output lands in a register:
   // on a load they see head 0 of the incoming frame, otherwise the next buffered head.
   always_comb begin
      accept   = out_valid && out_ready;
      last_acc = accept && (head == LAST);
      load     = in_valid && ((state == IDLE) || last_acc);
      adv      = accept && (head != LAST);
      nxt_head = (head == LAST) ? '0 : head + 1'b1;
      if (load) begin
         sel_q = in_q[0];
         sel_k = in_k[0];
         sel_v = in_v[0];
         sel_s = shift_amt;
      end else begin
         sel_q = q_buf[nxt_head];
         sel_k = k_buf[nxt_head];
         sel_v = v_buf[nxt_head];
         sel_s = shift_reg;
      end
   end

   requant_sat #(.ACC_W(ACC_W), .DW(DW)) u_rq_q (.x(sel_q), .s(sel_s), .r(rq_q), .sat(sat_q));
   requant_sat #(.ACC_W(ACC_W), .DW(DW)) u_rq_k (.x(sel_k), .s(sel_s), .r(rq_k), .sat(sat_k));
   requant_sat #(.ACC_W(ACC_W), .DW(DW)) u_rq_v (.x(sel_v), .s(sel_s), .r(rq_v), .sat(sat_v));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         head      <= '0;
         out_valid <= 1'b0;
         out_head  <= '0;
         out_q     <= '0;
         out_k     <= '0;
         out_v     <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (in_valid && !load) begin
            overflow <= 1'b1;
         end
         if (load) begin
            for (int i = 0; i < PE_NUM; i++) begin
               q_buf[i] <= in_q[i];
               k_buf[i] <= in_k[i];
               v_buf[i] <= in_v[i];
            end
            shift_reg <= shift_amt;
            state     <= STREAM;
            head      <= '0;
            out_valid <= 1'b1;
            out_head  <= '0;
            out_q     <= rq_q;
            out_k     <= rq_k;
            out_v     <= rq_v;
            out_last  <= (LAST == '0);
            busy      <= 1'b1;
         end else if (adv) begin
            head     <= nxt_head;
            out_head <= nxt_head;
            out_q    <= rq_q;
            out_k    <= rq_k;
            out_v    <= rq_v;
            out_last <= (nxt_head == LAST);
         end else if (last_acc) begin
            state     <= IDLE;
            head      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
         end
      end
   end

`ifdef QKV_SAT_CNT_EN
   logic [2:0]  beat_sat;
   logic [16:0] cnt_sum;

   // beat_sat tracks the flags of the beat currently on the outputs.
   always_comb begin
      cnt_sum = {1'b0, sat_count} + 17'(beat_sat[0]) + 17'(beat_sat[1]) + 17'(beat_sat[2]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_sat  <= '0;
         sat_count <= '0;
      end else begin
         if (load || adv) begin
            beat_sat <= {sat_v, sat_k, sat_q};
         end
         if (accept) begin
            sat_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
         end
      end
   end
`endif

endmodule

// File: tb/tb_qkv_requant_serializer.sv
// tb/tb_qkv_requant_serializer.sv - randomized self-checking bench against a behavioural beat model
module tb_qkv_requant_serializer;

   localparam int PE_NUM = 12;
   localparam int DW     = 4;
   localparam int ACC_W  = 18;
   localparam int HW     = 4;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    in_valid = 1'b0;
   logic signed [ACC_W-1:0] in_q [0:PE_NUM-1];
   logic signed [ACC_W-1:0] in_k [0:PE_NUM-1];
   logic signed [ACC_W-1:0] in_v [0:PE_NUM-1];
   logic [4:0]              shift_amt = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [HW-1:0]           out_head;
   logic signed [DW-1:0]    out_q;
   logic signed [DW-1:0]    out_k;
   logic signed [DW-1:0]    out_v;
   logic                    out_last;
   logic                    busy;
   logic                    overflow;
`ifdef QKV_SAT_CNT_EN
   logic [15:0]             sat_count;
`endif

   qkv_requant_serializer #(.PE_NUM(PE_NUM), .DW(DW), .N(768)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .in_q(in_q), .in_k(in_k), .in_v(in_v), .shift_amt(shift_amt),
      .out_valid(out_valid), .out_ready(out_ready), .out_head(out_head),
      .out_q(out_q), .out_k(out_k), .out_v(out_v), .out_last(out_last),
      .busy(busy), .overflow(overflow)
`ifdef QKV_SAT_CNT_EN
      , .sat_count(sat_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int head;
      int q;
      int k;
      int v;
      int last;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    ready_mode = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Round-half-up division by 2^s with floor semantics, then clamp to DW bits.
   function automatic int model_rq(input int x, input int sh);
      int     s;
      longint d, n, q;
      s = (sh > ACC_W - 1) ? ACC_W - 1 : sh;
      if (s == 0) begin
         q = x;
      end else begin
         d = longint'(1) << s;
         n = longint'(x) + d / 2;
         q = n / d;
         if ((n % d) != 0 && n < 0) q = q - 1;
      end
      if (q > 7)  q = 7;
      if (q < -8) q = -8;
      return int'(q);
   endfunction

   task automatic push_frame();
      beat_t b;
      for (int h = 0; h < PE_NUM; h++) begin
         b.head = h;
         b.q    = model_rq(int'(in_q[h]), int'(shift_amt));
         b.k    = model_rq(int'(in_k[h]), int'(shift_amt));
         b.v    = model_rq(int'(in_v[h]), int'(shift_amt));
         b.last = (h == PE_NUM - 1) ? 1 : 0;
         exp_q.push_back(b);
      end
   endtask

   function automatic logic signed [ACC_W-1:0] rand_acc();
      int v;
      if ($urandom_range(0, 1) == 1) return ACC_W'($urandom);
      v = int'($urandom_range(0, 400)) - 200;
      return ACC_W'(v);
   endfunction

   task automatic rand_frame();
      for (int h = 0; h < PE_NUM; h++) begin
         in_q[h] = rand_acc();
         in_k[h] = rand_acc();
         in_v[h] = rand_acc();
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         2:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   endtask

   task automatic send(input bit expect_it);
      in_valid = 1'b1;
      if (expect_it) push_frame();
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0 && !busy) break;
         step();
      end
      check("drain_left", exp_q.size(), 0);
      check("drain_busy", busy, 0);
   endtask

   task automatic wait_head(input int h);
      int found;
      found = 0;
      for (int i = 0; i < 100; i++) begin
         if (out_valid && out_head == h) begin
            found = 1;
            break;
         end
         step();
      end
      check("wait_head", found, 1);
   endtask

   // Every presented beat, stalled or accepted, must equal the model's head of queue.
   always @(negedge clk) begin
      beat_t b;
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", 1, 0);
         end else begin
            b = exp_q[0];
            check("head", out_head, b.head);
            check("q", out_q, b.q);
            check("k", out_k, b.k);
            check("v", out_v, b.v);
            check("last", out_last, b.last);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      for (int h = 0; h < PE_NUM; h++) begin
         in_q[h] = '0;
         in_k[h] = '0;
         in_v[h] = '0;
      end
      rst = 1'b1;
      ready_mode = 0;
      repeat (3) step();
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      check("rst_head", out_head, 0);
      check("rst_q", out_q, 0);
      check("rst_last", out_last, 0);
      rst = 1'b0;
      step();

      // Directed rounding and saturation frame
      rand_frame();
      shift_amt = 5'd3;
      in_q[0] = 18'sd13;
      in_k[0] = -18'sd13;
      in_v[0] = 18'sd100;
      in_q[1] = -18'sd100;
      send(1'b1);
      check("latency_valid", out_valid, 1);
      check("latency_head", out_head, 0);
      check("dir_q0", out_q, 2);
      check("dir_k0", out_k, -2);
      check("dir_v0", out_v, 7);
      step();
      check("dir_q1", out_q, -8);
      drain();

      // Backpressure toggling every cycle
      ready_mode = 1;
      rand_frame();
      shift_amt = 5'($urandom_range(0, 17));
      send(1'b1);
      drain();

      // Randomized frames including shift amounts beyond ACC_W-1
      for (int f = 0; f < 6; f++) begin
         ready_mode = f % 3;
         rand_frame();
         shift_amt = 5'($urandom_range(0, 31));
         send(1'b1);
         drain();
      end

      // Back-to-back frames on the last-beat accept
      ready_mode = 0;
      step();
      rand_frame();
      shift_amt = 5'd4;
      send(1'b1);
      wait_head(PE_NUM - 1);
      rand_frame();
      shift_amt = 5'd2;
      send(1'b1);
      check("b2b_valid", out_valid, 1);
      check("b2b_head", out_head, 0);
      check("b2b_ovf", overflow, 0);
      drain();

      // Dropped frame sets sticky overflow
      rand_frame();
      shift_amt = 5'd5;
      send(1'b1);
      wait_head(5);
      rand_frame();
      shift_amt = 5'd0;
      send(1'b0);
      check("ovf_set", overflow, 1);
      drain();
      check("ovf_sticky", overflow, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("ovf_clear", overflow, 0);

      // Reset in the middle of a frame
      rand_frame();
      shift_amt = 5'd6;
      send(1'b1);
      wait_head(7);
      rst = 1'b1;
      ready_mode = 3;
      out_ready = 1'b0;
      step();
      rst = 1'b0;
      exp_q.delete();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ovf", overflow, 0);
      ready_mode = 0;
      step();
      rand_frame();
      shift_amt = 5'd1;
      send(1'b1);
      check("post_rst_head", out_head, 0);
      check("post_rst_valid", out_valid, 1);
      drain();

      // All-positive-max frame with no shift saturates every element
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int h = 0; h < PE_NUM; h++) begin
         in_q[h] = 18'sd131071;
         in_k[h] = 18'sd131071;
         in_v[h] = 18'sd131071;
      end
      shift_amt = 5'd0;
      send(1'b1);
      drain();
`ifdef QKV_SAT_CNT_EN
      check("sat_count", sat_count, 36);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
